// File: rtl/regfile_mp_sb.sv
// Multi-read-port integer register file with a per-register busy scoreboard.
// Decode reads operands and allocates destinations. Writeback writes results
// and retires the matching busy bit. A write can be forwarded to a read of the
// same register in the same cycle. Register 0 can be hardwired to zero.
module regfile_mp_sb #(
   parameter int XLEN     = 64,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int RD_LAT   = 0,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*XLEN-1:0]   rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [XLEN-1:0]          wr_data,
   input  logic                     alloc_en,
   input  logic [ADDR_W-1:0]        alloc_addr,
   output logic [ADDR_W:0]          busy_cnt
);

   localparam int NUM_REGS = 2**ADDR_W;

   logic [XLEN-1:0]     regs [NUM_REGS];
   logic [NUM_REGS-1:0] busy;
   logic [NUM_REGS-1:0] busy_nxt;
   logic                wr_ok;
   logic                alloc_ok;

   // Writes and allocations that target a hardwired x0 are discarded.
   assign wr_ok    = wr_en    && !((ZERO_REG != 0) && (wr_addr    == '0));
   assign alloc_ok = alloc_en && !((ZERO_REG != 0) && (alloc_addr == '0));

   function automatic logic [ADDR_W:0] popcount(input logic [NUM_REGS-1:0] v);
      logic [ADDR_W:0] cnt;
      cnt = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         cnt = cnt + {{ADDR_W{1'b0}}, v[i]};
      end
      return cnt;
   endfunction

   // Register storage: writeback updates one entry per cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_ok) begin
         regs[wr_addr] <= wr_data;
      end
   end

   // Next scoreboard state: the retiring write clears first and a new
   // allocation sets afterwards, so a same-address pair leaves the entry busy.
   always_comb begin
      busy_nxt = busy;
      if (wr_en) begin
         busy_nxt[wr_addr] = 1'b0;
      end
      if (alloc_ok) begin
         busy_nxt[alloc_addr] = 1'b1;
      end
   end

   // Scoreboard and its population count; the count is taken from the next
   // state so that it always matches the registered busy vector.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy     <= '0;
         busy_cnt <= '0;
      end else begin
         busy     <= busy_nxt;
         busy_cnt <= popcount(busy_nxt);
      end
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [XLEN-1:0]   val;
      logic              bsy;

      assign addr = rd_addr[p*ADDR_W +: ADDR_W];

      // Per-port read value: zero register, then same-cycle forward, then storage.
      always_comb begin
         val = regs[addr];
         bsy = busy[addr];
         if ((ZERO_REG != 0) && (addr == '0)) begin
            val = '0;
            bsy = 1'b0;
         end else if ((BYPASS != 0) && wr_en && (wr_addr == addr)) begin
            val = wr_data;
            bsy = 1'b0;
         end
      end

      if (RD_LAT == 0) begin : g_comb
         assign rd_data[p*XLEN +: XLEN] = val;
         assign rd_busy[p]              = bsy;
      end else begin : g_reg
         logic [XLEN-1:0] val_q;
         logic            bsy_q;

         // Registered read port: value and busy visible one edge after the address.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               val_q <= '0;
               bsy_q <= 1'b0;
            end else begin
               val_q <= val;
               bsy_q <= bsy;
            end
         end

         assign rd_data[p*XLEN +: XLEN] = val_q;
         assign rd_busy[p]              = bsy_q;
      end
   end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: a default instance (2 ports, combinational reads)
// and a 4-port registered-read instance share the write/alloc stream and are
// compared every cycle against an array-based model of the register file.
module tb_regfile_mp_sb;

   logic         clk;
   logic         rst;
   logic         wr_en;
   logic [4:0]   wr_addr;
   logic [63:0]  wr_data;
   logic         alloc_en;
   logic [4:0]   alloc_addr;

   logic [9:0]   rd_addr0;
   logic [127:0] rd_data0;
   logic [1:0]   rd_busy0;
   logic [5:0]   busy_cnt0;

   logic [19:0]  rd_addr1;
   logic [255:0] rd_data1;
   logic [3:0]   rd_busy1;
   logic [5:0]   busy_cnt1;

   int errors = 0;
   int checks = 0;

   logic [63:0] m_reg  [32];
   logic        m_busy [32];
   logic [63:0] e1_data [4];
   logic        e1_busy [4];

   regfile_mp_sb dut0 (
      .clk(clk), .rst(rst),
      .rd_addr(rd_addr0), .rd_data(rd_data0), .rd_busy(rd_busy0),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .alloc_en(alloc_en), .alloc_addr(alloc_addr),
      .busy_cnt(busy_cnt0)
   );

   regfile_mp_sb #(.NUM_RD(4), .RD_LAT(1)) dut1 (
      .clk(clk), .rst(rst),
      .rd_addr(rd_addr1), .rd_data(rd_data1), .rd_busy(rd_busy1),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .alloc_en(alloc_en), .alloc_addr(alloc_addr),
      .busy_cnt(busy_cnt1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Model read rules: x0 reads 0, a same-cycle write forwards, else storage.
   function automatic logic [63:0] exp_v(input logic [4:0] a);
      if (a == 5'd0) return 64'd0;
      if (wr_en && wr_addr == a) return wr_data;
      return m_reg[a];
   endfunction

   function automatic logic exp_b(input logic [4:0] a);
      if (a == 5'd0) return 1'b0;
      if (wr_en && wr_addr == a) return 1'b0;
      return m_busy[a];
   endfunction

   function automatic logic [63:0] model_cnt();
      int n = 0;
      for (int i = 0; i < 32; i++) if (m_busy[i]) n++;
      return 64'(n);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m_reg[i]  = '0;
         m_busy[i] = 1'b0;
      end
      for (int p = 0; p < 4; p++) begin
         e1_data[p] = '0;
         e1_busy[p] = 1'b0;
      end
   endtask

   // One clock: check both instances on the falling edge, then apply the
   // rising edge to the model.
   task automatic cycle();
      logic [4:0] a;
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
         a = rd_addr0[p*5 +: 5];
         chk($sformatf("d0_data_p%0d", p), rd_data0[p*64 +: 64], exp_v(a));
         chk($sformatf("d0_busy_p%0d", p), 64'(rd_busy0[p]), 64'(exp_b(a)));
      end
      chk("d0_cnt", 64'(busy_cnt0), model_cnt());
      chk("d1_cnt", 64'(busy_cnt1), model_cnt());
      for (int p = 0; p < 4; p++) begin
         chk($sformatf("d1_data_p%0d", p), rd_data1[p*64 +: 64], e1_data[p]);
         chk($sformatf("d1_busy_p%0d", p), 64'(rd_busy1[p]), 64'(e1_busy[p]));
         a = rd_addr1[p*5 +: 5];
         e1_data[p] = exp_v(a);
         e1_busy[p] = exp_b(a);
      end
      @(posedge clk);
      if (wr_en) begin
         if (wr_addr != 5'd0) m_reg[wr_addr] = wr_data;
         m_busy[wr_addr] = 1'b0;
      end
      if (alloc_en && alloc_addr != 5'd0) m_busy[alloc_addr] = 1'b1;
      #1;
   endtask

   initial begin
      rst = 1'b1;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      alloc_en = 1'b0; alloc_addr = '0;
      rd_addr0 = '0; rd_addr1 = '0;
      model_reset();

      // Reset state on every register through both ports.
      #1;
      for (int a = 0; a < 32; a++) begin
         rd_addr0 = {5'(a), 5'(a)};
         #1;
         chk("rst_data_p0", rd_data0[63:0], 64'd0);
         chk("rst_data_p1", rd_data0[127:64], 64'd0);
         chk("rst_busy", 64'(rd_busy0), 64'd0);
      end
      chk("rst_cnt", 64'(busy_cnt0), 64'd0);
      chk("rst_d1_data", rd_data1[63:0], 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Legacy smoke test: write x20=15, read x10/x20.
      wr_en = 1'b1; wr_addr = 5'd20; wr_data = 64'd15; rd_addr0 = '0;
      cycle();
      wr_en = 1'b0; rd_addr0 = {5'd20, 5'd10};
      #1;
      chk("smoke_p0", rd_data0[63:0], 64'd0);
      chk("smoke_p1", rd_data0[127:64], 64'd15);
      cycle();

      // Same-cycle forward of a write to a busy register.
      alloc_en = 1'b1; alloc_addr = 5'd7;
      cycle();
      alloc_en = 1'b0;
      wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'hDEAD; rd_addr0 = {5'd0, 5'd7};
      #1;
      chk("byp_cnt", 64'(busy_cnt0), 64'd1);
      chk("byp_data", rd_data0[63:0], 64'hDEAD);
      chk("byp_busy", 64'(rd_busy0[0]), 64'd0);
      cycle();
      wr_en = 1'b0;

      // x0 ignores writes and allocation.
      wr_en = 1'b1; wr_addr = 5'd0; wr_data = 64'h55; rd_addr0 = '0;
      #1;
      chk("x0_fwd", rd_data0[63:0], 64'd0);
      cycle();
      wr_en = 1'b0; alloc_en = 1'b1; alloc_addr = 5'd0;
      cycle();
      alloc_en = 1'b0;
      #1;
      chk("x0_data", rd_data0[63:0], 64'd0);
      chk("x0_cnt", 64'(busy_cnt0), 64'd0);

      // Allocation counting and simultaneous write+alloc on one register.
      alloc_en = 1'b1; alloc_addr = 5'd5;
      cycle();
      alloc_addr = 5'd6;
      cycle();
      alloc_en = 1'b0; rd_addr0 = {5'd6, 5'd5};
      #1;
      chk("alloc_cnt", 64'(busy_cnt0), 64'd2);
      chk("alloc_busy", 64'(rd_busy0), 64'd3);
      wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hAA;
      alloc_en = 1'b1; alloc_addr = 5'd5;
      cycle();
      wr_en = 1'b0; alloc_en = 1'b0; rd_addr0 = {5'd5, 5'd5};
      #1;
      chk("wa_cnt", 64'(busy_cnt0), 64'd2);
      chk("wa_busy", 64'(rd_busy0[0]), 64'd1);
      chk("wa_data", rd_data0[63:0], 64'hAA);
      cycle();

      // Registered four-port read of x9 lands exactly one edge later.
      rd_addr1 = {4{5'd9}};
      cycle();
      wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'd3;
      #1;
      for (int p = 0; p < 4; p++) chk($sformatf("lat_pre_p%0d", p), rd_data1[p*64 +: 64], 64'd0);
      cycle();
      for (int p = 0; p < 4; p++) chk($sformatf("lat_post_p%0d", p), rd_data1[p*64 +: 64], 64'd3);
      wr_en = 1'b0;
      wr_en = 1'b1; wr_addr = 5'd13; wr_data = 64'h1234;
      cycle();
      wr_en = 1'b0;

      // Randomized traffic with bias towards forwarding hits.
      for (int i = 0; i < 300; i++) begin
         wr_en      = 1'($urandom_range(0, 1));
         wr_addr    = 5'($urandom_range(0, 31));
         wr_data    = {$urandom, $urandom};
         alloc_en   = 1'($urandom_range(0, 1));
         alloc_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
         for (int p = 0; p < 2; p++)
            rd_addr0[p*5 +: 5] = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
         for (int p = 0; p < 4; p++)
            rd_addr1[p*5 +: 5] = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
         cycle();
      end

      // Reset mid-operation, overriding a pending write and allocation.
      wr_en = 1'b1; wr_addr = 5'd13; wr_data = 64'h1234;
      alloc_en = 1'b0;
      cycle();
      rst = 1'b1;
      wr_en = 1'b1; wr_addr = 5'd14; wr_data = 64'hBEEF;
      alloc_en = 1'b1; alloc_addr = 5'd15;
      rd_addr0 = {5'd13, 5'd13}; rd_addr1 = {4{5'd13}};
      #1;
      chk("mid_rst_data", rd_data0[63:0], 64'd0);
      chk("mid_rst_cnt", 64'(busy_cnt0), 64'd0);
      chk("mid_rst_d1", rd_data1[63:0], 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0; wr_en = 1'b0; alloc_en = 1'b0;
      model_reset();
      rd_addr0 = {5'd15, 5'd14};
      #1;
      chk("post_rst_data", rd_data0[63:0], 64'd0);
      chk("post_rst_busy", 64'(rd_busy0[1]), 64'd0);
      chk("post_rst_cnt", 64'(busy_cnt0), 64'd0);
      wr_en = 1'b1; wr_addr = 5'd14; wr_data = 64'd7;
      alloc_en = 1'b1; alloc_addr = 5'd15;
      cycle();
      wr_en = 1'b0; alloc_en = 1'b0;
      #1;
      chk("first_edge_data", rd_data0[63:0], 64'd7);
      chk("first_edge_busy", 64'(rd_busy0[1]), 64'd1);
      chk("first_edge_cnt", 64'(busy_cnt0), 64'd1);
      for (int i = 0; i < 20; i++) begin
         wr_en      = 1'($urandom_range(0, 1));
         wr_addr    = 5'($urandom_range(0, 31));
         wr_data    = {$urandom, $urandom};
         alloc_en   = 1'($urandom_range(0, 1));
         alloc_addr = 5'($urandom_range(0, 31));
         rd_addr0   = 10'($urandom);
         rd_addr1   = 20'($urandom);
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
